// File: rtl/hazard_control_unit.sv
// -----------------------------------------------------------------------------
// hazard_control_unit
//   Pipeline hazard controller for the 5-stage RISC-V core, placed beside ID.
//   It resolves three kinds of hazard, highest priority first:
//     1. Data-memory wait freeze.
//     2. Taken-branch flush.
//     3. Load-use stall, lasting LOAD_USE_BUBBLES cycles.
//   It also keeps a saturating count of the cycles in which the PC is held.
//
// Ports
//   clk, rst_n       clock, synchronous active-low reset
//   id_inst          instruction currently in ID
//   ex_memread       EX instruction is a load
//   ex_rd            destination register of the EX instruction
//   ex_branch_taken  branch/jump resolved taken in EX
//   mem_req          MEM stage holds a load/store
//   dmem_ready       data memory completes the access this cycle
//   stall_cnt_clr    clear the stall counter
//   pc_write         PC write enable
//   ifid_write       IF/ID write enable
//   idex_bubble      load a NOP into ID/EX
//   ifid_flush       load a NOP into IF/ID
//   pipe_freeze      hold ID/EX, EX/MEM and MEM/WB
//   stall_cnt        number of cycles with pc_write=0 (saturating)
//   dbg_state        FSM state for observation (0=RUN, 1=LU_STALL)
//   dbg_bcnt         remaining-bubble down-counter for observation
//
// The control outputs are level signals. They are valid during every cycle and
// are combinational from the state and the inputs. There is no valid/ready
// handshake in this block.
// -----------------------------------------------------------------------------
module hazard_control_unit #(
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int REG_ADDR_W       = 5,
  parameter int IGNORE_X0        = 1,
  parameter int CNT_W            = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           id_inst,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  dmem_ready,
  input  logic                  stall_cnt_clr,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  idex_bubble,
  output logic                  ifid_flush,
  output logic                  pipe_freeze,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic                  dbg_state,
  output logic [1:0]            dbg_bcnt
);

  localparam logic       RUN         = 1'b0;
  localparam logic       LU_STALL    = 1'b1;
  localparam logic [1:0] BUBBLE_INIT = 2'(LOAD_USE_BUBBLES - 1);

  logic             state_q, state_d;
  logic [1:0]       bcnt_q, bcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Register-usage decode
  logic [6:0] opcode;
  logic       use_rs1, use_rs2;
  logic       rs1_match, rs2_match, rd_is_x0;
  logic       lu_hit, mem_wait;

  assign opcode  = id_inst[6:0];
  assign use_rs1 = !(opcode == 7'b0110111 || opcode == 7'b0010111 ||
                     opcode == 7'b1101111);
  assign use_rs2 = (opcode == 7'b0110011 || opcode == 7'b0100011 ||
                    opcode == 7'b1100011);

  assign rs1_match = use_rs1 && (ex_rd == id_inst[15 +: REG_ADDR_W]);
  assign rs2_match = use_rs2 && (ex_rd == id_inst[20 +: REG_ADDR_W]);
  assign rd_is_x0  = (IGNORE_X0 != 0) && (ex_rd == '0);
  assign lu_hit    = ex_memread && (rs1_match || rs2_match) && !rd_is_x0;
  assign mem_wait  = mem_req && !dmem_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      bcnt_q  <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. A freeze holds the state and bcnt.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    if (!mem_wait) begin
      case (state_q)
        RUN: begin
          // The hazard cycle itself is the first bubble. Only the extra
          // bubbles are spent in LU_STALL.
          if (!ex_branch_taken && lu_hit && (LOAD_USE_BUBBLES > 1)) begin
            state_d = LU_STALL;
            bcnt_d  = BUBBLE_INIT;
          end
        end
        default: begin
          if (bcnt_q == 2'd1) begin
            state_d = RUN;
            bcnt_d  = 2'd0;
          end else begin
            bcnt_d = bcnt_q - 2'd1;
          end
        end
      endcase
    end
  end

  // Output logic
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    pipe_freeze = 1'b0;
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      ifid_flush  = 1'b1;
    end else if (mem_wait) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      pipe_freeze = 1'b1;
    end else if (state_q == RUN && ex_branch_taken) begin
      // The dependent instruction is squashed, so any lu_hit is irrelevant.
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (state_q == RUN && lu_hit) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (state_q == LU_STALL) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // Stall counter. A clear wins over an increment. The count saturates at
  // all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (stall_cnt_clr) begin
      cnt_d = '0;
    end else if (!pc_write && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign stall_cnt = cnt_q;
  assign dbg_state = state_q;
  assign dbg_bcnt  = bcnt_q;

endmodule
